// File: rtl/gray_pkg.sv
// Shared definitions for gray-code consumers: default sizing and a helper
// that detects an illegal multi-bit gray transition.
package gray_pkg;

    localparam int DEFAULT_VEC_W       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MAX_VEC_W           = 64;

    // True when more than one bit of the difference vector is set.
    // Clearing the lowest set bit leaves something behind only if at least
    // two bits were set, so no adder tree is needed.
    function automatic logic popcount_gt1(input logic [MAX_VEC_W-1:0] diff);
        return (diff & (diff - MAX_VEC_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational gray-to-binary decode, usable by any gray consumer.
module gray_to_bin #(
    parameter int VEC_W = 4
) (
    input  logic [VEC_W-1:0] gray_i,
    output logic [VEC_W-1:0] bin_o
);

    // Each binary bit is the running XOR of all gray bits from the MSB down.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_o = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive side of a gray-coded pointer link: synchronizes the incoming gray
// vector, decodes it to binary, reports the advance since the last sample,
// and flags illegal multi-bit gray transitions.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int VEC_W       = DEFAULT_VEC_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [VEC_W-1:0] gray_i,
    input  logic             clr_err_i,
    output logic [VEC_W-1:0] bin_o,
    output logic [VEC_W-1:0] step_o,
    output logic             chg_o,
    output logic             valid_o,
    output logic             err_o
);

    localparam int WARM_COUNT = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(WARM_COUNT + 1);
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARM_COUNT);

    logic [VEC_W-1:0] sync_q [SYNC_STAGES];
    logic [VEC_W-1:0] g_sync;
    logic [VEC_W-1:0] g_prev;
    logic [VEC_W-1:0] bin_next;
    logic [CNT_W-1:0] warm_cnt;
    logic             multi_bit;

    assign g_sync    = sync_q[SYNC_STAGES-1];
    assign multi_bit = popcount_gt1(MAX_VEC_W'(g_sync ^ g_prev));

    gray_to_bin #(
        .VEC_W (VEC_W)
    ) u_decode (
        .gray_i (g_sync),
        .bin_o  (bin_next)
    );

    // Synchronizer chain; only the last stage is ever looked at by logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Warm-up counter saturates once the chain holds real samples; valid
    // rises on the edge where the count reaches its final value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
            valid_o  <= 1'b0;
        end else begin
            if (warm_cnt != WARM_MAX) warm_cnt <= warm_cnt + CNT_W'(1);
            if (warm_cnt >= WARM_MAX - CNT_W'(1)) valid_o <= 1'b1;
        end
    end

    // Decode register: binary value, advance, change pulse and sticky error.
    // Step, change and error stay quiet until warm-up is done so the reset
    // contents of the chain never look like a real transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_o  <= '0;
            g_prev <= '0;
            step_o <= '0;
            chg_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            bin_o  <= bin_next;
            g_prev <= g_sync;
            if (valid_o) begin
                step_o <= bin_next - bin_o;
                chg_o  <= (bin_next != bin_o);
                if (multi_bit)      err_o <= 1'b1;
                else if (clr_err_i) err_o <= 1'b0;
            end else begin
                step_o <= '0;
                chg_o  <= 1'b0;
                err_o  <= 1'b0;
            end
        end
    end

endmodule
